counter_sequencer: RTL and testbench

Control unit that sequences the board's up/down counter datapath from pushbutton commands. Synchronizes and edge-detects active-low keys, runs a start/pause/clear/load state machine, and issues single-cycle enable, clear and load strobes at a prescaled rate. Sits between the DE-series `KEY`/`SW` inputs and the counter, and exposes its state for display on `LEDR`.

---
 rtl/counter_sequencer_pkg.sv | 7 +
 rtl/key_edge_sync.sv | 26 ++
 rtl/counter_sequencer.sv | 65 ++++++
 tb/tb_counter_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer_pkg: state encoding and key command indices for the counter sequencer
package counter_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  localparam int KEY_RUN = 0;
  localparam int KEY_CLR = 1;
  localparam int KEY_LD  = 2;
endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync: 2-FF synchronizer and single-cycle falling-edge pulse for one active-low key
module key_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pulse
);
  logic s1, s2, prev, live, armed;
  // armed stays low until the key is seen released, so a key held through reset never fires
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      prev  <= 1'b1;
      live  <= 1'b0;
      armed <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      prev  <= s2;
      live  <= 1'b1;
      armed <= armed | (live & s1);
      pulse <= armed & prev & ~s2;
    end
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: key-driven start/pause/clear/load FSM issuing prescaled counter strobes
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int CNT_W    = 10,
  parameter int PRESCALE = 50000000,
  parameter int LIMIT    = 1023,
  parameter int WRAP     = 0
) (
  input  logic             CLOCK_50,
  input  logic             Resetn,
  input  logic [2:0]       key_n,
  input  logic [CNT_W-1:0] sw,
  input  logic             up_sw,
  input  logic [CNT_W-1:0] count,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             cnt_ld,
  output logic [CNT_W-1:0] ld_val,
  output logic             cnt_up,
  output logic [1:0]       state
);
  localparam int PRE_W = $clog2(PRESCALE);
  logic [2:0] cmd;
  state_t st;
  logic [1:0] st_nxt;
  logic [PRE_W-1:0] pre, pre_nxt;
  logic in_run, tick, term, ld_ok, start;
  for (genvar i = 0; i < 3; i++) begin : g_key
    key_edge_sync u_sync (.clk(CLOCK_50), .rst_n(Resetn), .key_n(key_n[i]), .pulse(cmd[i]));
  end
  // the prescaler advances in every RUN cycle, including the one that pauses, so tick spacing counts RUN cycles only
  always_comb begin
    in_run  = st == RUN;
    tick    = pre == PRE_W'(PRESCALE - 1);
    term    = (WRAP == 0) && (count == (cnt_up ? CNT_W'(LIMIT) : CNT_W'(0)));
    ld_ok   = cmd[KEY_LD] && !cmd[KEY_CLR] && !in_run;
    start   = cmd[KEY_RUN] && !cmd[KEY_CLR] && !ld_ok && st == IDLE;
    st_nxt  = cmd[KEY_CLR] ? IDLE :
              in_run ? (term ? DONE : cmd[KEY_RUN] ? PAUSE : RUN) :
              ld_ok ? (st == DONE ? IDLE : st) :
              (cmd[KEY_RUN] && st != DONE) ? RUN : st;
    pre_nxt = (cmd[KEY_CLR] || start) ? '0 :
              (in_run && !term) ? (tick ? '0 : pre + 1'b1) : pre;
  end
  always_ff @(posedge CLOCK_50 or negedge Resetn)
    if (!Resetn) begin
      st      <= IDLE;
      pre     <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      cnt_ld  <= 1'b0;
      ld_val  <= '0;
      cnt_up  <= 1'b1;
    end else begin
      st      <= state_t'(st_nxt);
      pre     <= pre_nxt;
      cnt_en  <= in_run && tick && !term && !cmd[KEY_CLR];
      cnt_clr <= cmd[KEY_CLR];
      cnt_ld  <= ld_ok;
      ld_val  <= ld_ok ? sw : ld_val;
      cnt_up  <= start ? up_sw : cnt_up;
    end
  assign state = st;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed checks of counter_sequencer with a behavioral counter in the loop
module tb_counter_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] key_n;
  logic [3:0] sw;
  logic       up_sw;
  logic [3:0] count;
  logic       cnt_en, cnt_clr, cnt_ld, cnt_up;
  logic [3:0] ld_val;
  logic [1:0] state;
  int checks = 0;
  int errors = 0;
  int n;
  logic quiet;
  always #5 clk = ~clk;
  counter_sequencer #(.CNT_W(4), .PRESCALE(4), .LIMIT(5), .WRAP(0)) dut (
    .CLOCK_50(clk), .Resetn(rst_n), .key_n(key_n), .sw(sw), .up_sw(up_sw), .count(count),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .cnt_ld(cnt_ld), .ld_val(ld_val), .cnt_up(cnt_up), .state(state)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (cnt_clr) count <= '0;
    else if (cnt_ld) count <= ld_val;
    else if (cnt_en) count <= cnt_up ? count + 4'd1 : count - 4'd1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic press(input logic [2:0] m);
    key_n = ~m;
    repeat (4) @(posedge clk);
    @(negedge clk);
    key_n = 3'b111;
  endtask
  task automatic wait_en(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cnt_en && cyc < 40);
    check("en_seen", {31'd0, cnt_en}, 1);
  endtask
  task automatic watch_quiet(input int cyc);
    quiet = 1'b1;
    repeat (cyc) begin
      @(negedge clk);
      if (cnt_en || cnt_clr || cnt_ld) quiet = 1'b0;
    end
  endtask
  initial begin
    rst_n = 1'b1; key_n = 3'b111; sw = '0; up_sw = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_state", state, 0);
    check("rst_en", cnt_en, 0);
    check("rst_clr", cnt_clr, 0);
    check("rst_ld", cnt_ld, 0);
    check("rst_ldval", ld_val, 0);
    check("rst_up", cnt_up, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    press(3'b001);
    check("start_state", state, 1);
    check("start_up", cnt_up, 1);
    for (int i = 0; i < 5; i++) begin
      wait_en(n);
      check("up_gap", n, 4);
      check("up_count", count, i);
    end
    repeat (2) @(negedge clk);
    check("done_state", state, 3);
    check("done_count", count, 5);
    watch_quiet(20);
    check("done_quiet", quiet, 1);
    sw = 4'd3;
    press(3'b100);
    check("ld_pulse", cnt_ld, 1);
    check("ld_val", ld_val, 3);
    check("ld_state", state, 0);
    @(negedge clk);
    check("ld_width", cnt_ld, 0);
    check("ld_count", count, 3);
    up_sw = 1'b0;
    press(3'b001);
    check("dn_up", cnt_up, 0);
    for (int i = 0; i < 3; i++) begin
      wait_en(n);
      check("dn_count", count, 3 - i);
    end
    repeat (2) @(negedge clk);
    check("dn_done", state, 3);
    check("dn_zero", count, 0);
    press(3'b010);
    check("clr_pulse", cnt_clr, 1);
    check("clr_state", state, 0);
    @(negedge clk);
    check("clr_width", cnt_clr, 0);
    up_sw = 1'b1;
    press(3'b001);
    wait_en(n);
    check("p_first", n, 4);
    repeat (2) @(negedge clk);
    press(3'b001);
    check("pause_state", state, 2);
    check("pause_count", count, 2);
    watch_quiet(10);
    check("pause_quiet", quiet, 1);
    press(3'b001);
    check("resume_state", state, 1);
    wait_en(n);
    check("resume_gap", n, 2);
    check("resume_count", count, 2);
    press(3'b001);
    check("pause2_state", state, 2);
    press(3'b110);
    check("both_clr", cnt_clr, 1);
    check("both_ld", cnt_ld, 0);
    check("both_state", state, 0);
    @(negedge clk);
    check("both_count", count, 0);
    press(3'b001);
    check("run_state", state, 1);
    sw = 4'd7;
    press(3'b100);
    check("run_ld", cnt_ld, 0);
    check("run_ld_state", state, 1);
    up_sw = 1'b0;
    repeat (3) @(negedge clk);
    check("dir_hold", cnt_up, 1);
    wait_en(n);
    #2 rst_n = 1'b0;
    key_n[0] = 1'b0;
    #1;
    check("async_en", cnt_en, 0);
    check("async_state", state, 0);
    check("async_up", cnt_up, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch_quiet(10);
    check("held_quiet", quiet, 1);
    check("held_state", state, 0);
    key_n = 3'b111;
    repeat (3) @(negedge clk);
    press(3'b001);
    check("rearm_state", state, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
